// File: rtl/inv_nibble_decoder_if.sv
// Link interface for the inverted-nibble counter receiver.
// b_in is declared [0:3] so that b_in[0] is the (inverted) MSB of the nibble.
interface inv_nibble_decoder_if #(
  parameter int ERR_W = 8
);
  logic             in_valid;
  logic [0:3]       b_in;
  logic             c_in;
  logic [7:0]       a_out;
  logic             out_valid;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_count;

  // Link side: drives samples, observes decoder status
  modport master (
    output in_valid, b_in, c_in,
    input  a_out, out_valid, locked, err, err_count
  );

  // Decoder side
  modport slave (
    input  in_valid, b_in, c_in,
    output a_out, out_valid, locked, err, err_count
  );
endinterface

// File: rtl/inv_nibble_decoder.sv
// Receive side of the inverted-nibble counter link.
// Recovers the low nibble from b_in, checks the c_in bit, verifies the +1
// sequence, rebuilds the 8-bit count by tracking nibble wraps, and reports
// lock / error status with a saturating error counter.
// Optional: define INV_NIBBLE_STICKY_ERR_EN to make err sticky until rst;
// otherwise err is a one-cycle pulse per bad sample while LOCKED.
module inv_nibble_decoder #(
  parameter int LOCK_CNT = 3,  // good +1 steps needed to lock (1..7)
  parameter int LOSS_CNT = 2,  // consecutive bad samples to lose lock (1..7)
  parameter int ERR_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  inv_nibble_decoder_if.slave   bus
);

  typedef enum logic {HUNT, LOCKED} state_t;

  localparam logic [2:0]       LOCK_LAST = 3'(LOCK_CNT - 1);
  localparam logic [2:0]       LOSS_LAST = 3'(LOSS_CNT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

  state_t           state_q, state_d;
  logic [3:0]       prev_nib_q, prev_nib_d;
  logic [3:0]       hi_nib_q, hi_nib_d;
  logic             have_prev_q, have_prev_d;
  logic [2:0]       run_q, run_d;
  logic [2:0]       bad_q, bad_d;
  logic [7:0]       a_q, a_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic [3:0] nib;
  logic       check_ok;
  logic       step_ok;
  logic       sample_good;
  logic       wrap;

  // The [0:3] -> [3:0] assignment maps b_in[0] onto the numeric MSB.
  assign nib         = ~bus.b_in;
  assign check_ok    = (bus.c_in == (nib[1] & nib[0]));
  assign step_ok     = have_prev_q && (nib == prev_nib_q + 4'd1);
  // With no predecessor only the check bit can disqualify a sample.
  assign sample_good = check_ok && (step_ok || !have_prev_q);
  assign wrap        = (prev_nib_q == 4'hF) && (nib == 4'h0);

  // Next-state and output computation; everything holds unless in_valid.
  always_comb begin
    state_d     = state_q;
    prev_nib_d  = prev_nib_q;
    hi_nib_d    = hi_nib_q;
    have_prev_d = have_prev_q;
    run_d       = run_q;
    bad_d       = bad_q;
    a_d         = a_q;
    out_valid_d = 1'b0;
    err_count_d = err_count_q;
`ifdef INV_NIBBLE_STICKY_ERR_EN
    err_d       = err_q;
`else
    err_d       = 1'b0;
`endif

    if (bus.in_valid) begin
      prev_nib_d  = nib;
      have_prev_d = 1'b1;
      // A wrap advances the high nibble even if the sample is otherwise bad.
      hi_nib_d    = wrap ? hi_nib_q + 4'd1 : hi_nib_q;
      a_d         = {hi_nib_d, nib};
      out_valid_d = 1'b1;

      unique case (state_q)
        HUNT: begin
          if (!sample_good) begin
            run_d = 3'd0;
          end else if (have_prev_q) begin
            if (run_q == LOCK_LAST) begin
              // hi_nib only moves on wraps, so it already holds the reload
              // value (0 if no wrap has been seen since reset).
              state_d = LOCKED;
              run_d   = 3'd0;
            end else begin
              run_d = run_q + 3'd1;
            end
          end
        end
        LOCKED: begin
          if (sample_good) begin
            bad_d = 3'd0;
          end else begin
            err_d = 1'b1;
            if (err_count_q != ERR_MAX) begin
              err_count_d = err_count_q + ERR_W'(1);
            end
            if (bad_q == LOSS_LAST) begin
              state_d = HUNT;
              bad_d   = 3'd0;
              run_d   = 3'd0;
            end else begin
              bad_d = bad_q + 3'd1;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      prev_nib_q  <= 4'd0;
      hi_nib_q    <= 4'd0;
      have_prev_q <= 1'b0;
      run_q       <= 3'd0;
      bad_q       <= 3'd0;
      a_q         <= 8'd0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      prev_nib_q  <= prev_nib_d;
      hi_nib_q    <= hi_nib_d;
      have_prev_q <= have_prev_d;
      run_q       <= run_d;
      bad_q       <= bad_d;
      a_q         <= a_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.a_out     = a_q;
  assign bus.out_valid = out_valid_q;
  assign bus.locked    = (state_q == LOCKED);
  assign bus.err       = err_q;
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_inv_nibble_decoder.sv
// Scoreboard bench for inv_nibble_decoder: directed link scenarios followed
// by randomized traffic, checked against a behavioural model of the link.
module tb_inv_nibble_decoder;

  localparam int LOCK_CNT = 3;
  localparam int LOSS_CNT = 2;
  localparam int EW       = 4;
  localparam int EMAX     = (1 << EW) - 1;

  typedef struct {
    int a;
    int lk;
    int er;
    int ec;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  inv_nibble_decoder_if #(.ERR_W(EW)) bus ();

  inv_nibble_decoder #(
    .LOCK_CNT(LOCK_CNT),
    .LOSS_CNT(LOSS_CNT),
    .ERR_W   (EW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  exp_t q[$];

  // Model state: plain integers
  int   m_prev, m_have, m_hi, m_locked, m_run, m_bad, m_errc, m_sticky;
  exp_t m_hold;      // expected outputs while no new sample arrives
  int   ta;          // true count driven onto the link

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_have = 0; m_hi = 0; m_locked = 0;
    m_run = 0; m_bad = 0; m_errc = 0; m_sticky = 0;
    m_hold = '{a: 0, lk: 0, er: 0, ec: 0};
  endtask

  // Apply one link sample to the model and return the expected outputs.
  task automatic model_step(input logic [0:3] b, input logic c, output exp_t e);
    int nib, chk, stepok, good, bad_now;
    nib = (b[0] ? 0 : 8) + (b[1] ? 0 : 4) + (b[2] ? 0 : 2) + (b[3] ? 0 : 1);
    chk = (int'(c) == ((nib % 4 == 3) ? 1 : 0));
    stepok = m_have && (((nib - m_prev + 16) % 16) == 1);
    good = chk && (!m_have || stepok);
    if (m_prev == 15 && nib == 0) m_hi = (m_hi + 1) % 16;
    bad_now = 0;
    if (!m_locked) begin
      if (!good) m_run = 0;
      else if (m_have) m_run++;
      if (m_run == LOCK_CNT) begin
        m_locked = 1;
        m_run = 0;
      end
    end else if (good) begin
      m_bad = 0;
    end else begin
      bad_now = 1;
      m_sticky = 1;
      m_bad++;
      if (m_errc < EMAX) m_errc++;
      if (m_bad == LOSS_CNT) begin
        m_locked = 0; m_bad = 0; m_run = 0;
      end
    end
    m_prev = nib;
    m_have = 1;
    e.a  = m_hi * 16 + nib;
    e.lk = m_locked;
    e.ec = m_errc;
`ifdef INV_NIBBLE_STICKY_ERR_EN
    e.er = m_sticky;
    m_hold = '{a: e.a, lk: e.lk, er: m_sticky, ec: e.ec};
`else
    e.er = bad_now;
    m_hold = '{a: e.a, lk: e.lk, er: 0, ec: e.ec};
`endif
  endtask

  // Drive one sample of true count a (optionally corrupting c_in).
  task automatic send_a(input int a, input bit flip);
    logic [7:0] av;
    logic [0:3] b;
    logic       c;
    exp_t       e;
    av = 8'(a);
    b  = ~av[3:0];
    c  = (av[1] & av[0]) ^ flip;
    bus.in_valid = 1'b1;
    bus.b_in     = b;
    bus.c_in     = c;
    @(posedge clk);
    model_step(b, c, e);
    q.push_back(e);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_out"},     int'(bus.a_out), 0);
    check({tag, "_out_valid"}, int'(bus.out_valid), 0);
    check({tag, "_locked"},    int'(bus.locked), 0);
    check({tag, "_err"},       int'(bus.err), 0);
    check({tag, "_err_count"}, int'(bus.err_count), 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a sample.
  initial begin
    bit   v;
    exp_t e;
    forever begin
      @(posedge clk);
      v = bus.in_valid && !rst;
      @(negedge clk);
      check("out_valid", int'(bus.out_valid), int'(v));
      if (v) begin
        if (q.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = q.pop_front();
          check("a_out",     int'(bus.a_out), e.a);
          check("locked",    int'(bus.locked), e.lk);
          check("err",       int'(bus.err), e.er);
          check("err_count", int'(bus.err_count), e.ec);
        end
      end else begin
        check("hold_a_out",     int'(bus.a_out), m_hold.a);
        check("hold_locked",    int'(bus.locked), m_hold.lk);
        check("hold_err",       int'(bus.err), m_hold.er);
        check("hold_err_count", int'(bus.err_count), m_hold.ec);
      end
    end
  end

  // Stimulus
  initial begin
    int r;
    model_reset();
    bus.in_valid = 1'b0;
    bus.b_in     = 4'b0000;
    bus.c_in     = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    rst = 1'b0;
    idle(1);

    // Count 0..6 (lock after A=3), gap, A=7 with bad check bit, 8..21
    // through the 15->0 wrap, then two step errors (25, 29) and relock.
    for (int a = 0; a <= 6; a++) send_a(a, 1'b0);
    idle(4);
    send_a(7, 1'b1);
    for (int a = 8; a <= 21; a++) send_a(a, 1'b0);
    send_a(25, 1'b0);
    send_a(29, 1'b0);
    for (int a = 30; a <= 34; a++) send_a(a, 1'b0);
    ta = 34;

    // Randomized traffic: mostly good counting with gaps, jumps, bad checks.
    for (int i = 0; i < 700; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 10) idle(int'($urandom_range(1, 3)));
      r = int'($urandom_range(0, 99));
      if (r < 6) ta = int'($urandom_range(0, 255));
      else ta = (ta + 1) % 256;
      send_a(ta, ($urandom_range(0, 99) < 8));
    end

    // Re-lock, then assert reset asynchronously in the middle of a cycle.
    for (int i = 0; i < 6; i++) begin
      ta = (ta + 1) % 256;
      send_a(ta, 1'b0);
    end
    idle(2);
    check("locked_before_rst", int'(bus.locked), m_locked);
    @(posedge clk);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_all_zero("async_rst");
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    idle(1);

    // First sample after reset has no predecessor; then lock again.
    for (int a = 200; a <= 206; a++) send_a(a, 1'b0);
    idle(3);
    check("sb_drain", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
